// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 message sequencer.
package md5_pkg;

    localparam int BLOCK_W     = 512;
    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;
    localparam int LEN_FIELD_W = 64;
    localparam int LEN_LO_IDX  = 14;
    localparam int LEN_HI_IDX  = 15;

    localparam logic [7:0]  PAD_BYTE = 8'h80;

    localparam logic [31:0] MD5_IV_A = 32'h67452301;
    localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
    localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
    localparam logic [31:0] MD5_IV_D = 32'h10325476;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PAD  = 3'd2,
        ST_RUN  = 3'd3,
        ST_WAIT = 3'd4,
        ST_ACC  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Block buffer write operations
    typedef enum logic [2:0] {
        BUF_NOP  = 3'd0,
        BUF_WORD = 3'd1,  // plain message word
        BUF_LAST = 3'd2,  // final word: keep nbytes bytes, 0x80 after them, zero the rest
        BUF_MARK = 3'd3,  // 0x80 in byte 0, rest zero
        BUF_ZERO = 3'd4,  // zero word
        BUF_LEN  = 3'd5,  // 64-bit bit length into words 14/15
        BUF_CLR  = 3'd6   // whole block to zero
    } buf_op_t;

    // Final message word with the padding marker placed right after the valid bytes.
    function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                  input logic [2:0]  nbytes);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(nbytes)) begin
                w[8*b +: 8] = data[8*b +: 8];
            end else if (b == int'(nbytes)) begin
                w[8*b +: 8] = PAD_BYTE;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/md5_blk_buf.sv
// 16x32 block buffer feeding the MD5 core; word 0 sits in the low bits of blk.
module md5_blk_buf
    import md5_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         op,
    input  logic [3:0]         idx,
    input  logic [31:0]        wr_data,
    input  logic [2:0]         nbytes,
    input  logic [63:0]        len,
    output logic [BLOCK_W-1:0] blk
);

    logic [WORD_W-1:0] mem_q [BLOCK_WORDS];
    logic [WORD_W-1:0] mem_d [BLOCK_WORDS];

    // Next buffer contents for the requested operation
    always_comb begin
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            mem_d[k] = mem_q[k];
        end
        case (op)
            BUF_WORD: mem_d[idx] = wr_data;
            BUF_LAST: mem_d[idx] = pad_last_word(wr_data, nbytes);
            BUF_MARK: mem_d[idx] = {24'h000000, PAD_BYTE};
            BUF_ZERO: mem_d[idx] = '0;
            BUF_LEN: begin
                mem_d[LEN_LO_IDX] = len[31:0];
                mem_d[LEN_HI_IDX] = len[63:32];
            end
            BUF_CLR: begin
                for (int k = 0; k < BLOCK_WORDS; k++) begin
                    mem_d[k] = '0;
                end
            end
            default: ;
        endcase
    end

    // Buffer storage, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < BLOCK_WORDS; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < BLOCK_WORDS; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    for (genvar k = 0; k < BLOCK_WORDS; k++) begin : g_flat
        assign blk[WORD_W*k +: WORD_W] = mem_q[k];
    end

endmodule

// File: rtl/md5_msg_ctrl.sv
// MD5 message sequencer: packs the word stream into blocks, pads, runs the
// compression core once per block and accumulates the chaining value.
module md5_msg_ctrl
    import md5_pkg::*;
#(
    parameter logic [31:0] IV_A    = MD5_IV_A,
    parameter logic [31:0] IV_B    = MD5_IV_B,
    parameter logic [31:0] IV_C    = MD5_IV_C,
    parameter logic [31:0] IV_D    = MD5_IV_D,
    parameter int          LEN_W   = 32,
    parameter int          CORE_TO = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         busy,
    output logic         digest_valid,
    output logic [127:0] digest,
    output logic         err,
    output logic [511:0] core_string,
    output logic [31:0]  core_A,
    output logic [31:0]  core_B,
    output logic [31:0]  core_C,
    output logic [31:0]  core_D,
    output logic         core_en,
    input  logic         core_complete,
    input  logic [31:0]  core_a,
    input  logic [31:0]  core_b,
    input  logic [31:0]  core_c,
    input  logic [31:0]  core_d
);

    localparam int TMR_W = $clog2(CORE_TO + 1);

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               digest_valid_q, digest_valid_d;
    logic [127:0]       digest_q, digest_d;
    logic               err_q, err_d;
    logic               core_en_q, core_en_d;
    logic [31:0]        h_a_q, h_a_d, h_b_q, h_b_d, h_c_q, h_c_d, h_d_q, h_d_d;
    logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [4:0]         word_idx_q, word_idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               complete_q, complete_d;
    logic               armed_q, armed_d;
    logic               final_q, final_d;
    logic               len_pend_q, len_pend_d;
    logic               pad80_q, pad80_d;

    buf_op_t            buf_op;
    logic [2:0]         nbytes;
    logic [2:0]         inc;
    logic [LEN_W:0]     cnt_sum;
    logic [63:0]        len_field;
    logic               accept;
    logic               core_done;

    md5_blk_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (buf_op),
        .idx     (word_idx_q[3:0]),
        .wr_data (in_data),
        .nbytes  (nbytes),
        .len     (len_field),
        .blk     (core_string)
    );

    // Sequencer next-state and datapath updates
    always_comb begin
        state_d        = state_q;
        in_ready_d     = in_ready_q;
        busy_d         = busy_q;
        digest_valid_d = digest_valid_q;
        digest_d       = digest_q;
        err_d          = err_q;
        core_en_d      = 1'b0;
        h_a_d          = h_a_q;
        h_b_d          = h_b_q;
        h_c_d          = h_c_q;
        h_d_d          = h_d_q;
        byte_cnt_d     = byte_cnt_q;
        word_idx_d     = word_idx_q;
        timer_d        = timer_q;
        complete_d     = complete_q;
        armed_d        = 1'b1;
        final_d        = final_q;
        len_pend_d     = len_pend_q;
        pad80_d        = pad80_q;
        buf_op         = BUF_NOP;

        // in_bytes beyond 4 is treated as a full word
        nbytes    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        inc       = in_last ? nbytes : 3'd4;
        cnt_sum   = {1'b0, byte_cnt_q} + (LEN_W+1)'(inc);
        len_field = LEN_FIELD_W'({byte_cnt_q, 3'b000});
        accept    = in_valid & in_ready_q;
        core_done = (core_complete != complete_q);

        // Baseline of the toggle handshake is taken once after reset
        if (!armed_q) begin
            complete_d = core_complete;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    digest_valid_d = 1'b0;
                    err_d          = 1'b0;
                    h_a_d          = IV_A;
                    h_b_d          = IV_B;
                    h_c_d          = IV_C;
                    h_d_d          = IV_D;
                    byte_cnt_d     = '0;
                    word_idx_d     = '0;
                    final_d        = 1'b0;
                    len_pend_d     = 1'b0;
                    pad80_d        = 1'b0;
                    busy_d         = 1'b1;
                    in_ready_d     = 1'b1;
                    state_d        = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (cnt_sum[LEN_W]) begin
                        err_d      = 1'b1;
                        busy_d     = 1'b0;
                        in_ready_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        byte_cnt_d = cnt_sum[LEN_W-1:0];
                        word_idx_d = word_idx_q + 5'd1;
                        if (in_last) begin
                            buf_op     = BUF_LAST;
                            // a full last word pushes the marker into the next word
                            pad80_d    = (nbytes == 3'd4);
                            in_ready_d = 1'b0;
                            state_d    = ST_PAD;
                        end else begin
                            buf_op = BUF_WORD;
                            if (word_idx_q == 5'd15) begin
                                in_ready_d = 1'b0;
                                state_d    = ST_RUN;
                            end
                        end
                    end
                end
            end
            ST_PAD: begin
                if (word_idx_q == 5'd14 && !pad80_q) begin
                    buf_op  = BUF_LEN;
                    final_d = 1'b1;
                    state_d = ST_RUN;
                end else if (word_idx_q == 5'd16) begin
                    // block filled by data; marker (if pending) and length go in the next one
                    len_pend_d = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    buf_op     = pad80_q ? BUF_MARK : BUF_ZERO;
                    pad80_d    = 1'b0;
                    word_idx_d = word_idx_q + 5'd1;
                    if (word_idx_q == 5'd15) begin
                        len_pend_d = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                core_en_d = 1'b1;
                timer_d   = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    complete_d = core_complete;
                    state_d    = ST_ACC;
                end else if (timer_q == TMR_W'(CORE_TO - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_ACC: begin
                h_a_d = h_a_q + core_a;
                h_b_d = h_b_q + core_b;
                h_c_d = h_c_q + core_c;
                h_d_d = h_d_q + core_d;
                word_idx_d = '0;
                if (final_q) begin
                    state_d = ST_DONE;
                end else if (len_pend_q) begin
                    buf_op     = BUF_CLR;
                    len_pend_d = 1'b0;
                    state_d    = ST_PAD;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_DONE: begin
                digest_d       = {h_d_q, h_c_q, h_b_q, h_a_q};
                digest_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            digest_valid_q <= 1'b0;
            digest_q       <= '0;
            err_q          <= 1'b0;
            core_en_q      <= 1'b0;
            h_a_q          <= IV_A;
            h_b_q          <= IV_B;
            h_c_q          <= IV_C;
            h_d_q          <= IV_D;
            byte_cnt_q     <= '0;
            word_idx_q     <= '0;
            timer_q        <= '0;
            complete_q     <= 1'b0;
            armed_q        <= 1'b0;
            final_q        <= 1'b0;
            len_pend_q     <= 1'b0;
            pad80_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            digest_valid_q <= digest_valid_d;
            digest_q       <= digest_d;
            err_q          <= err_d;
            core_en_q      <= core_en_d;
            h_a_q          <= h_a_d;
            h_b_q          <= h_b_d;
            h_c_q          <= h_c_d;
            h_d_q          <= h_d_d;
            byte_cnt_q     <= byte_cnt_d;
            word_idx_q     <= word_idx_d;
            timer_q        <= timer_d;
            complete_q     <= complete_d;
            armed_q        <= armed_d;
            final_q        <= final_d;
            len_pend_q     <= len_pend_d;
            pad80_q        <= pad80_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign digest_valid = digest_valid_q;
    assign digest       = digest_q;
    assign err          = err_q;
    assign core_en      = core_en_q;
    assign core_A       = h_a_q;
    assign core_B       = h_b_q;
    assign core_C       = h_c_q;
    assign core_D       = h_d_q;

endmodule

// File: tb/tb_md5_msg_ctrl.sv
// Bench for md5_msg_ctrl: behavioural MD5 core plus a byte-level MD5 reference.
module tb_md5_msg_ctrl;

    localparam logic [31:0] IVA = 32'h67452301;
    localparam logic [31:0] IVB = 32'hefcdab89;
    localparam logic [31:0] IVC = 32'h98badcfe;
    localparam logic [31:0] IVD = 32'h10325476;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [2:0]   in_bytes = '0;
    logic         busy, digest_valid, err, core_en;
    logic [127:0] digest;
    logic [511:0] core_string;
    logic [31:0]  core_A, core_B, core_C, core_D;
    logic         core_complete = 1'b0;
    logic [31:0]  core_a = '0, core_b = '0, core_c = '0, core_d = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    int SH [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    // message under test and observations of the core interface
    logic [7:0]   msg_q [$];
    logic [511:0] seen_blk [$];
    logic [127:0] seen_h [$];
    logic [127:0] core_res [$];
    logic [511:0] ref_blk [$];
    logic [127:0] ref_dig;
    int           en_pulses = 0;
    bit           core_hang = 1'b0;
    int           core_lat = 2;

    md5_msg_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_bytes      (in_bytes),
        .busy          (busy),
        .digest_valid  (digest_valid),
        .digest        (digest),
        .err           (err),
        .core_string   (core_string),
        .core_A        (core_A),
        .core_B        (core_B),
        .core_C        (core_C),
        .core_D        (core_D),
        .core_en       (core_en),
        .core_complete (core_complete),
        .core_a        (core_a),
        .core_b        (core_b),
        .core_c        (core_c),
        .core_d        (core_d)
    );

    always #5 clk = ~clk;

    // 64 MD5 rounds over one block, without the final feed-forward; h = {D,C,B,A}
    function automatic logic [127:0] md5_rounds(input logic [511:0] blk, input logic [127:0] h);
        logic [31:0] a, b, c, d, f, t;
        int g, s;
        a = h[31:0]; b = h[63:32]; c = h[95:64]; d = h[127:96];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7*i) % 16; end
            s = SH[(i/16)*4 + (i%4)];
            t = a + f + K[i] + blk[32*g +: 32];
            a = d; d = c; c = b;
            b = b + ((t << s) | (t >> (32 - s)));
        end
        return {d, c, b, a};
    endfunction

    // Reference: pad msg_q byte-wise, split into blocks, chain from the IV
    task automatic compute_ref(output logic [127:0] dig);
        logic [7:0]   p [$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        logic [127:0] h, r;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bitlen = 64'(msg_q.size()) * 64'd8;
        for (int i = 0; i < 8; i++) p.push_back(bitlen[8*i +: 8]);
        ref_blk.delete();
        h = {IVD, IVC, IVB, IVA};
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++) blk[8*j +: 8] = p[64*bi + j];
            ref_blk.push_back(blk);
            r = md5_rounds(blk, h);
            for (int w = 0; w < 4; w++) h[32*w +: 32] = h[32*w +: 32] + r[32*w +: 32];
        end
        dig = h;
    endtask

    // Behavioural core: launches on core_en rise, toggles complete after core_lat cycles
    logic         en_prev = 1'b0;
    bit           pend = 1'b0;
    int           cnt = 0;
    logic [127:0] res;
    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev = 1'b0;
            pend = 1'b0;
        end else begin
            if (en_prev) begin
                vectors++;
                if (core_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL core_en_width: core_en=%b second cycle, required 0", core_en);
                end
            end
            if (core_en === 1'b1 && !en_prev) begin
                en_pulses++;
                seen_blk.push_back(core_string);
                seen_h.push_back({core_D, core_C, core_B, core_A});
                if (!core_hang) begin
                    res = md5_rounds(core_string, {core_D, core_C, core_B, core_A});
                    core_res.push_back(res);
                    pend = 1'b1;
                    cnt = core_lat;
                end
            end
            en_prev = core_en;
            if (pend) begin
                if (cnt == 0) begin
                    {core_d, core_c, core_b, core_a} = res;
                    core_complete = ~core_complete;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_words(input bit gaps);
        int len, nw, n, g;
        logic [31:0] w;
        len = msg_q.size();
        nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            for (int b = 0; b < 4; b++)
                w[8*b +: 8] = (4*i + b < len) ? msg_q[4*i + b] : 8'($urandom);
            in_valid = 1'b1;
            in_data  = w;
            in_last  = (i == nw - 1);
            in_bytes = in_last ? 3'(len - 4*i) : 3'($urandom_range(0, 7));
            n = 0;
            while (in_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_digest();
        int n = 0;
        while (digest_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        vectors++;
        if (digest_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL digest_valid_wait: digest_valid=%b, required 1", digest_valid);
        end
    endtask

    task automatic run_msg(input bit gaps);
        seen_blk.delete(); seen_h.delete(); core_res.delete();
        en_pulses = 0;
        compute_ref(ref_dig);
        do_start();
        send_words(gaps);
        wait_digest();
    endtask

    task automatic set_abc();
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 9;
        if (in_ready !== 1'b0)     begin miscompares++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        if (busy !== 1'b0)         begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (digest_valid !== 1'b0) begin miscompares++; $display("FAIL rst_digest_valid: got %b, required 0", digest_valid); end
        if (digest !== '0)         begin miscompares++; $display("FAIL rst_digest: got %h, required 0", digest); end
        if (err !== 1'b0)          begin miscompares++; $display("FAIL rst_err: got %b, required 0", err); end
        if (core_en !== 1'b0)      begin miscompares++; $display("FAIL rst_core_en: got %b, required 0", core_en); end
        if (core_string !== '0)    begin miscompares++; $display("FAIL rst_core_string: got nonzero, required 0"); end
        if ({core_D, core_C, core_B, core_A} !== {IVD, IVC, IVB, IVA})
            begin miscompares++; $display("FAIL rst_core_iv: got %h, required %h", {core_D, core_C, core_B, core_A}, {IVD, IVC, IVB, IVA}); end
        rst_n = 1'b1;
        @(negedge clk);
        if (in_ready !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_rst: in_ready=%b busy=%b, required 0 0", in_ready, busy); end
    endtask

    task automatic test_empty();
        logic [127:0] kv, kexp;
        kv = 128'hd41d8cd98f00b204e9800998ecf8427e;
        kexp = {<<8{kv}};
        msg_q.delete();
        run_msg(1'b0);
        vectors += 4;
        if (en_pulses != 1) begin miscompares++; $display("FAIL empty_pulses: got %0d, required 1", en_pulses); end
        if (digest !== kexp) begin miscompares++; $display("FAIL empty_digest: got %h, required %h", digest, kexp); end
        if (seen_blk.size() > 0) begin
            if (seen_blk[0][31:0] !== 32'h00000080) begin miscompares++; $display("FAIL empty_word0: got %h, required 00000080", seen_blk[0][31:0]); end
            if (seen_blk[0][511:448] !== 64'd0) begin miscompares++; $display("FAIL empty_len: got %h, required 0", seen_blk[0][511:448]); end
        end else begin
            miscompares += 2; $display("FAIL empty_block: no block seen, required 1");
        end
    endtask

    task automatic test_abc();
        logic [127:0] kv, kexp;
        kv = 128'h900150983cd24fb0d6963f7d28e17f72;
        kexp = {<<8{kv}};
        set_abc();
        run_msg(1'b0);
        vectors += 3;
        if (digest !== kexp) begin miscompares++; $display("FAIL abc_digest: got %h, required %h", digest, kexp); end
        if (seen_blk.size() > 0) begin
            if (seen_blk[0][31:0] !== 32'h80636261) begin miscompares++; $display("FAIL abc_word0: got %h, required 80636261", seen_blk[0][31:0]); end
            if (seen_blk[0][32*14 +: 32] !== 32'd24) begin miscompares++; $display("FAIL abc_word14: got %0d, required 24", seen_blk[0][32*14 +: 32]); end
        end else begin
            miscompares += 2; $display("FAIL abc_block: no block seen, required 1");
        end
    endtask

    task automatic test_pad_boundary();
        logic [511:0] eb;
        logic [127:0] ch;
        int lens [3] = '{55, 56, 64};
        for (int t = 0; t < 3; t++) begin
            msg_q.delete();
            for (int i = 0; i < lens[t]; i++) msg_q.push_back(8'($urandom));
            core_lat = $urandom_range(0, 4);
            run_msg(1'b1);
            vectors += 2;
            if (en_pulses != (lens[t] == 55 ? 1 : 2)) begin miscompares++; $display("FAIL pad_pulses_%0d: got %0d, required %0d", lens[t], en_pulses, (lens[t] == 55 ? 1 : 2)); end
            if (digest !== ref_dig) begin miscompares++; $display("FAIL pad_digest_%0d: got %h, required %h", lens[t], digest, ref_dig); end
            if (lens[t] != 55 && seen_blk.size() == 2 && core_res.size() >= 1) begin
                eb = '0;
                eb[32*14 +: 32] = 32'(lens[t] * 8);
                if (lens[t] == 64) eb[31:0] = 32'h00000080;
                ch = {IVD + core_res[0][127:96], IVC + core_res[0][95:64], IVB + core_res[0][63:32], IVA + core_res[0][31:0]};
                vectors += 2;
                if (seen_blk[1] !== eb) begin miscompares++; $display("FAIL pad_blk2_%0d: word0=%h word14=%0d, required %h %0d", lens[t], seen_blk[1][31:0], seen_blk[1][32*14 +: 32], eb[31:0], lens[t] * 8); end
                if (seen_h[1] !== ch) begin miscompares++; $display("FAIL pad_chain_%0d: got %h, required %h", lens[t], seen_h[1], ch); end
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(0, 150);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            core_lat = $urandom_range(0, 6);
            run_msg(1'($urandom_range(0, 1)));
            vectors += 2;
            if (digest !== ref_dig) begin miscompares++; $display("FAIL rand_digest len=%0d: got %h, required %h", len, digest, ref_dig); end
            if (en_pulses != ref_blk.size()) begin miscompares++; $display("FAIL rand_pulses len=%0d: got %0d, required %0d", len, en_pulses, ref_blk.size()); end
            for (int k = 0; k < ref_blk.size() && k < seen_blk.size(); k++) begin
                vectors++;
                if (seen_blk[k] !== ref_blk[k]) begin miscompares++; $display("FAIL rand_block len=%0d blk=%0d: got %h, required %h", len, k, seen_blk[k][63:0], ref_blk[k][63:0]); end
            end
        end
    endtask

    task automatic test_timeout();
        int p0, n;
        logic [127:0] kv, kexp;
        kv = 128'h900150983cd24fb0d6963f7d28e17f72;
        kexp = {<<8{kv}};
        core_hang = 1'b1;
        set_abc();
        p0 = en_pulses;
        do_start();
        send_words(1'b0);
        n = 0;
        while (en_pulses == p0 && n < 200) begin @(negedge clk); n++; end
        vectors++;
        if (en_pulses == p0) begin miscompares++; $display("FAIL to_core_en: no core_en pulse, required 1"); end
        repeat (60) @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL to_early: err=%b at 60 cycles, required 0", err); end
        n = 0;
        while (err !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        vectors += 3;
        if (err !== 1'b1) begin miscompares++; $display("FAIL to_err: err=%b, required 1", err); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL to_busy: busy=%b, required 0", busy); end
        if (digest_valid !== 1'b0) begin miscompares++; $display("FAIL to_digest_valid: got %b, required 0", digest_valid); end
        core_hang = 1'b0;
        do_start();
        vectors += 2;
        if (err !== 1'b0) begin miscompares++; $display("FAIL to_err_clear: err=%b, required 0", err); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL to_busy_restart: busy=%b, required 1", busy); end
        compute_ref(ref_dig);
        send_words(1'b0);
        wait_digest();
        vectors++;
        if (digest !== kexp) begin miscompares++; $display("FAIL to_recover_digest: got %h, required %h", digest, kexp); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [127:0] kv, kexp;
        kv = 128'h900150983cd24fb0d6963f7d28e17f72;
        kexp = {<<8{kv}};
        do_start();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = $urandom; in_last = 1'b0; in_bytes = 3'd4;
            n = 0;
            while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        in_data = $urandom;
        rst_n = 1'b0;
        #1;
        vectors += 6;
        if (in_ready !== 1'b0)     begin miscompares++; $display("FAIL mid_in_ready: got %b, required 0", in_ready); end
        if (busy !== 1'b0)         begin miscompares++; $display("FAIL mid_busy: got %b, required 0", busy); end
        if (digest_valid !== 1'b0) begin miscompares++; $display("FAIL mid_digest_valid: got %b, required 0", digest_valid); end
        if (digest !== '0)         begin miscompares++; $display("FAIL mid_digest: got %h, required 0", digest); end
        if (core_string !== '0)    begin miscompares++; $display("FAIL mid_core_string: got nonzero, required 0"); end
        if (core_A !== IVA)        begin miscompares++; $display("FAIL mid_core_A: got %h, required %h", core_A, IVA); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_abc();
        run_msg(1'b0);
        vectors++;
        if (digest !== kexp) begin miscompares++; $display("FAIL mid_abc_digest: got %h, required %h", digest, kexp); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_pad_boundary();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
